// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared state encoding, vector count and golden model for the full_adder BIST
//   state_t   : IDLE, SETTLE, CHECK, DONE
//   fa_golden : returns the expected {carry,sum} for a 3-bit vector {cin,y,x}
package full_adder_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    localparam int NUM_VECTORS = 8;
    localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);
    function automatic logic [1:0] fa_golden(input logic [2:0] vec);
        return {(vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]), ^vec};
    endfunction
endpackage

// File: rtl/full_adder_bist.sv
// full_adder_bist: exhaustive self-test controller for a 1-bit full adder
//   iCLK, iRST (async, active-high), iSTART (level, accepted in IDLE/DONE)
//   oX/oY/oCIN : registered stimulus, {oCIN,oY,oX} = current vector index
//   iSUM/iCARRY: adder outputs under test
//   oBUSY, oDONE, oPASS, oERR_CNT (0..8), oFAIL_VEC (first failing vector)
module full_adder_bist
    import full_adder_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    output logic       oX,
    output logic       oY,
    output logic       oCIN,
    input  logic       iSUM,
    input  logic       iCARRY,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oPASS,
    output logic [3:0] oERR_CNT,
    output logic [2:0] oFAIL_VEC
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [2:0] fail_q, fail_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    assign mismatch = {iCARRY, iSUM} != fa_golden(vec_q);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (iSTART) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            SETTLE: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == SETTLE_LAST ? CHECK : SETTLE;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d  = err_q + 4'd1;
                    fail_d = err_q == 4'd0 ? vec_q : fail_q;
                end
                // The last vector or an early stop ends the run; vec never wraps back to 0.
                if (vec_q == LAST_VEC || (mismatch && STOP_ON_FAIL)) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                end
            end
        endcase
        // Status flags are decoded from the next state so they are registered alongside it.
        busy_d = state_d == SETTLE || state_d == CHECK;
        done_d = state_d == DONE;
        pass_d = done_d && err_d == 4'd0;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign oX        = vec_q[0];
    assign oY        = vec_q[1];
    assign oCIN      = vec_q[2];
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oPASS     = pass_q;
    assign oERR_CNT  = err_q;
    assign oFAIL_VEC = fail_q;
endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: directed bench for full_adder_bist across three parameter sets
module tb_full_adder_bist;
    typedef struct {
        int         sel;
        bit         fault;
        int         extra;
        int         exp_cyc;
        logic [3:0] exp_err;
        logic [2:0] exp_fail;
        logic       exp_pass;
        logic [2:0] exp_stim;
    } run_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fault = 1'b0;
    logic [2:0] start = '0;
    wire  [2:0] done, busy, pass_o, sum, carry;
    wire  [2:0][2:0] stim;
    wire  [2:0][3:0] err;
    wire  [2:0][2:0] fvec;
    int passed = 0;
    int total = 0;
    run_t runs[5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_fa
        assign sum[g]   = stim[g][0] ^ stim[g][1] ^ stim[g][2];
        assign carry[g] = fault ? 1'b0 : (stim[g][0] & stim[g][1]) | (stim[g][0] & stim[g][2]) | (stim[g][1] & stim[g][2]);
    end

    full_adder_bist #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) u_a (
        .iCLK(clk), .iRST(rst), .iSTART(start[0]),
        .oX(stim[0][0]), .oY(stim[0][1]), .oCIN(stim[0][2]),
        .iSUM(sum[0]), .iCARRY(carry[0]),
        .oBUSY(busy[0]), .oDONE(done[0]), .oPASS(pass_o[0]),
        .oERR_CNT(err[0]), .oFAIL_VEC(fvec[0])
    );

    full_adder_bist #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) u_b (
        .iCLK(clk), .iRST(rst), .iSTART(start[1]),
        .oX(stim[1][0]), .oY(stim[1][1]), .oCIN(stim[1][2]),
        .iSUM(sum[1]), .iCARRY(carry[1]),
        .oBUSY(busy[1]), .oDONE(done[1]), .oPASS(pass_o[1]),
        .oERR_CNT(err[1]), .oFAIL_VEC(fvec[1])
    );

    full_adder_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_c (
        .iCLK(clk), .iRST(rst), .iSTART(start[2]),
        .oX(stim[2][0]), .oY(stim[2][1]), .oCIN(stim[2][2]),
        .iSUM(sum[2]), .iCARRY(carry[2]),
        .oBUSY(busy[2]), .oDONE(done[2]), .oPASS(pass_o[2]),
        .oERR_CNT(err[2]), .oFAIL_VEC(fvec[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run(input run_t r);
        int  n;
        int  bad;
        bit  seen;
        int  exp_s;
        fault = r.fault;
        @(negedge clk);
        start[r.sel] = 1'b1;
        @(posedge clk);
        #1 start[r.sel] = 1'b0;
        chk($sformatf("accept_busy%0d", r.sel), int'(busy[r.sel]), 1);
        chk($sformatf("accept_done%0d", r.sel), int'(done[r.sel]), 0);
        chk($sformatf("accept_err%0d", r.sel), int'(err[r.sel]), 0);
        n = 0;
        bad = (stim[r.sel] != 3'd0) ? 1 : 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == r.extra) start[r.sel] = 1'b1;
            if (n == r.extra + 1) start[r.sel] = 1'b0;
            exp_s = n / 3 > 7 ? 7 : n / 3;
            if (int'(stim[r.sel]) != exp_s) bad++;
            seen = done[r.sel];
        end
        start[r.sel] = 1'b0;
        chk($sformatf("done_cycles%0d", r.sel), n, r.exp_cyc);
        if (r.sel == 0) chk("stim_sequence", bad, 0);
        chk($sformatf("err_cnt%0d", r.sel), int'(err[r.sel]), int'(r.exp_err));
        chk($sformatf("fail_vec%0d", r.sel), int'(fvec[r.sel]), int'(r.exp_fail));
        chk($sformatf("pass%0d", r.sel), int'(pass_o[r.sel]), int'(r.exp_pass));
        chk($sformatf("stim_hold%0d", r.sel), int'(stim[r.sel]), int'(r.exp_stim));
        chk($sformatf("busy_end%0d", r.sel), int'(busy[r.sel]), 0);
        repeat (3) @(posedge clk);
        #1 chk($sformatf("done_held%0d", r.sel), int'(done[r.sel]), 1);
    endtask

    initial begin
        runs[0] = '{0, 1'b1, 0, 24, 4'd4, 3'd3, 1'b0, 3'd7};
        runs[1] = '{0, 1'b0, 5, 24, 4'd0, 3'd0, 1'b1, 3'd7};
        runs[2] = '{1, 1'b1, 0, 12, 4'd1, 3'd3, 1'b0, 3'd3};
        runs[3] = '{1, 1'b0, 0, 24, 4'd0, 3'd0, 1'b1, 3'd7};
        runs[4] = '{2, 1'b0, 0, 16, 4'd0, 3'd0, 1'b1, 3'd7};
        #3;
        chk("rst_stim", int'(stim[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_pass", int'(pass_o[0]), 0);
        chk("rst_err", int'(err[0]), 0);
        chk("rst_fvec", int'(fvec[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run(runs[i]);
        // asynchronous reset during vector 4 SETTLE of a faulty run
        fault = 1'b1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("mid_stim", int'(stim[0]), 4);
        chk("mid_err", int'(err[0]), 1);
        chk("mid_busy", int'(busy[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stim", int'(stim[0]), 0);
        chk("arst_err", int'(err[0]), 0);
        chk("arst_fvec", int'(fvec[0]), 0);
        chk("arst_busy", int'(busy[0]), 0);
        chk("arst_done", int'(done[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        run('{0, 1'b0, 0, 24, 4'd0, 3'd0, 1'b1, 3'd7});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
